// File: rtl/serial_rx_controller.sv
// Receive-frame sequencer: aligns the bit detector on a start edge, then assembles
// start/data/parity/stop samples into a holding register with CPU read handshake.
module serial_rx_controller #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 serial_clock_i,
  input  logic                 serial_reset_i,
  input  logic                 serial_rx_enable_i,
  input  logic                 serial_transition_detected_i,
  input  logic                 serial_shift_i,
  input  logic                 serial_sample_detected_i,
  output logic                 serial_clear_count_o,
  output logic [DATA_BITS-1:0] serial_rx_data_o,
  output logic                 serial_rx_valid_o,
  input  logic                 serial_rx_read_i,
  output logic                 serial_framing_error_o,
  output logic                 serial_parity_error_o,
  output logic                 serial_overrun_o,
  output logic                 serial_rx_busy_o
);

  localparam logic [3:0] LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);
  localparam logic       ParOdd   = (PARITY_ODD != 0);
  localparam logic       ParEn    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } state_e;

  state_e                 state_q;
  logic [2:0]             shift_sync_q;
  logic [1:0]             sample_sync_q;
  logic [3:0]             bit_cnt_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   par_acc_q;
  logic                   ferr_q;
  logic                   perr_q;
  logic                   strobe;
  logic                   bit_in;

  // Both detector signals come from the baud domain; only the falling edge of shift is used.
  always_ff @(posedge serial_clock_i or posedge serial_reset_i) begin
    if (serial_reset_i) begin
      shift_sync_q  <= '0;
      sample_sync_q <= '0;
    end else begin
      shift_sync_q  <= {shift_sync_q[1:0], serial_shift_i};
      sample_sync_q <= {sample_sync_q[0], serial_sample_detected_i};
    end
  end

  assign strobe           = shift_sync_q[2] & ~shift_sync_q[1];
  assign bit_in           = sample_sync_q[1];
  assign serial_rx_busy_o = (state_q != StIdle);

  always_ff @(posedge serial_clock_i or posedge serial_reset_i) begin
    if (serial_reset_i) begin
      state_q                <= StIdle;
      bit_cnt_q              <= '0;
      shreg_q                <= '0;
      par_acc_q              <= 1'b0;
      ferr_q                 <= 1'b0;
      perr_q                 <= 1'b0;
      serial_clear_count_o   <= 1'b0;
      serial_rx_data_o       <= '0;
      serial_rx_valid_o      <= 1'b0;
      serial_framing_error_o <= 1'b0;
      serial_parity_error_o  <= 1'b0;
      serial_overrun_o       <= 1'b0;
    end else begin
      serial_clear_count_o <= 1'b0;

      // A load from DONE below overrides this clear when both happen together.
      if (serial_rx_read_i && serial_rx_valid_o) begin
        serial_rx_valid_o      <= 1'b0;
        serial_overrun_o       <= 1'b0;
        serial_framing_error_o <= 1'b0;
        serial_parity_error_o  <= 1'b0;
      end

      if (!serial_rx_enable_i && (state_q != StIdle)) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (serial_rx_enable_i && serial_transition_detected_i) begin
              serial_clear_count_o <= 1'b1;
              state_q              <= StStart;
            end
          end
          StStart: begin
            if (strobe) begin
              if (!bit_in) begin
                bit_cnt_q <= '0;
                par_acc_q <= 1'b0;
                ferr_q    <= 1'b0;
                perr_q    <= 1'b0;
                state_q   <= StData;
              end else begin
                state_q <= StIdle;
              end
            end
          end
          StData: begin
            if (strobe) begin
              shreg_q   <= {bit_in, shreg_q[DATA_BITS-1:1]};
              par_acc_q <= par_acc_q ^ bit_in;
              if (bit_cnt_q == LastData) begin
                // Counter is reused to count stop bits.
                bit_cnt_q <= '0;
                state_q   <= ParEn ? StParity : StStop;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          StParity: begin
            if (strobe) begin
              perr_q  <= ((par_acc_q ^ bit_in) != ParOdd);
              state_q <= StStop;
            end
          end
          StStop: begin
            if (strobe) begin
              if (!bit_in) begin
                ferr_q <= 1'b1;
              end
              if (bit_cnt_q == LastStop) begin
                state_q <= StDone;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          StDone: begin
            state_q <= StIdle;
            if (!serial_rx_valid_o || serial_rx_read_i) begin
              serial_rx_data_o       <= shreg_q;
              serial_framing_error_o <= ferr_q;
              serial_parity_error_o  <= perr_q;
              serial_rx_valid_o      <= 1'b1;
            end else begin
              serial_overrun_o <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/serial_rx_controller.md
Name: serial_rx_controller

Overview:
- Receive-frame sequencer for the serial module's bit detector.
- On a 1-to-0 start edge it pulses clear-count to phase-align the detector's oversampling counter, then consumes one majority-voted sample per bit strobe: start, data LSB-first, optional parity, stop.
- Assembles the byte into a holding register with valid/read handshake toward the CPU interface, plus framing, parity and overrun status.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even (used only when PARITY_EN=1).
- STOP_BITS, 1, number of stop bits checked (1 or 2).

Ports:
- serial_clock_i  in  1  system clock.
- serial_reset_i  in  1  asynchronous, active-high reset.
- serial_rx_enable_i  in  1  receiver enable.
- serial_transition_detected_i  in  1  start-edge pulse from the detector (serial_clock_i domain).
- serial_shift_i  in  1  detector shift flag (baud domain, asynchronous here).
- serial_sample_detected_i  in  1  detector voted bit (baud domain, asynchronous here).
- serial_clear_count_o  out  1  one-cycle pulse that realigns the detector counter.
- serial_rx_data_o  out  DATA_BITS  received data holding register.
- serial_rx_valid_o  out  1  holding register full.
- serial_rx_read_i  in  1  one-cycle CPU read strobe.
- serial_framing_error_o  out  1  a stop bit was sampled as 0.
- serial_parity_error_o  out  1  parity mismatch.
- serial_overrun_o  out  1  a frame completed while the holding register was full.
- serial_rx_busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, FSM = IDLE, synchronizers cleared, shift register and bit counter 0.
- Synchronization:
  - serial_shift_i passes through a 3-flop chain; bit strobe = 1 on the cycle the 2nd flop is 0 and the 3rd is 1 (falling edge of shift).
  - serial_sample_detected_i passes through 2 flops; its synchronized value is captured on the strobe cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - enable=1 and transition_detected=1: pulse clear_count for exactly 1 cycle, go to START.
  - Otherwise stay in IDLE.
- START (on strobe):
  - sample=0: clear bit_cnt, go to DATA.
  - sample=1: false start, go to IDLE. No flags, no valid.
- DATA (on strobe):
  - Shift right, new bit enters the MSB (LSB-first), running parity XOR updated, bit_cnt++.
  - When bit_cnt reaches DATA_BITS-1 and its strobe is taken: go to PARITY if PARITY_EN, else STOP.
- PARITY (on strobe):
  - perr = (xor of data ^ parity bit) != PARITY_ODD.
  - Go to STOP.
- STOP (on strobe):
  - sample=0 sets the internal ferr; any stop bit at 0 sets it.
  - After STOP_BITS strobes, go to DONE.
- DONE: lasts 1 cycle, then IDLE. Updates registered on exit from DONE (visible the next cycle):
  - If valid=0, or read=1 in the same cycle: load data, framing_error=ferr, parity_error=perr, valid=1.
  - Else: overrun=1; data and error flags keep the old frame.
- Read:
  - read=1 clears valid, overrun, framing_error and parity_error, unless DONE loads in the same cycle; DONE wins.
  - read while valid=0: no effect.
- Edge ignoring: transition_detected outside IDLE is ignored. Strobes in IDLE are ignored.
- Abort: enable=0 in any non-IDLE state returns the FSM to IDLE next cycle. No valid, no flags; the holding register is untouched.
- busy is combinational: state != IDLE.
- Width rules:
  - bit_cnt is 4 bits.
  - Parity is DATA_BITS-wide XOR plus the parity bit.
  - No counter wraps within a legal frame.

Test Plan:
- 8N1, byte 0x55, correct stop -> one clear_count pulse; valid=1 with data=0x55; framing_error=0, parity_error=0; busy low after DONE.
- Glitch edge, start strobe samples 1 -> FSM back to IDLE; valid stays 0; exactly 1 clear_count pulse.
- 8N1, byte 0xA3, stop bit sampled 0 -> valid=1, data=0xA3, framing_error=1. Read strobe -> valid=0, framing_error=0.
- PARITY_EN=1, even parity, byte 0x07 with parity bit 0 -> parity_error=1. Repeat with parity bit 1 -> parity_error=0.
- Two frames 0x11 then 0x22, no read in between -> data=0x11, overrun=1. Read coincident with the second DONE -> data=0x22, valid=1, overrun=0.
- enable dropped during the 4th data bit, and reset asserted mid-frame in a separate run -> FSM in IDLE, no valid; after reset all outputs are 0.
